// File: rtl/clint_timer.sv
// clint_timer: memory-mapped machine timer on the core data bus.
//   64-bit mtime / mtimecmp, level interrupt to I_int[0], one-cycle registered
//   bus response.
// Optional feature macro: TIMER_PRESCALE_EN
//   defined   -> PRESC register and prescale counter throttle the mtime tick.
//   undefined -> mtime ticks every cycle while EN=1, PRESC reads 0 and ignores writes.
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   I_req, I_we     bus request / write strobe
//   I_addr          byte address; [31:5] decoded, [4:2] register offset, [1:0] ignored
//   I_wdata, I_mask write data and byte enables
//   O_rdata         read data, valid while O_ready = 1
//   O_ready         response pulse one cycle after an accepted request
//   O_timer_int     registered level interrupt: IE & (mtime >= mtimecmp)
module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        I_req,
  input  logic        I_we,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_wdata,
  input  logic [3:0]  I_mask,
  output logic [31:0] O_rdata,
  output logic        O_ready,
  output logic        O_timer_int
);

  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 64;
  localparam int unsigned OFF_W = 3;

  localparam logic [OFF_W-1:0] OFF_CTRL   = 3'd0;
  localparam logic [OFF_W-1:0] OFF_PRESC  = 3'd1;
  localparam logic [OFF_W-1:0] OFF_MT_LO  = 3'd2;
  localparam logic [OFF_W-1:0] OFF_MT_HI  = 3'd3;
  localparam logic [OFF_W-1:0] OFF_CMP_LO = 3'd4;
  localparam logic [OFF_W-1:0] OFF_CMP_HI = 3'd5;

  // Byte-lane merge of write data into an existing 32-bit register value.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [3:0]    mask);
    logic [DW-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  logic             sel_c;
  logic             wr_c;
  logic             rd_c;
  logic [OFF_W-1:0] off_c;
  logic             tick_c;
  logic [DW-1:0]    rdata_c;
  logic [TW-1:0]    mtime_nxt_c;
  logic [TW-1:0]    mtimecmp_nxt_c;
  logic             unused_c;

  logic             en;
  logic             ie;
  logic [TW-1:0]    mtime;
  logic [TW-1:0]    mtimecmp;

  // Address decode: the whole 32-byte window answers, including reserved slots.
  assign sel_c    = I_req && (I_addr[31:5] == BASE_ADDR[31:5]);
  assign wr_c     = sel_c && I_we;
  assign rd_c     = sel_c && !I_we;
  assign off_c    = I_addr[4:2];
  assign unused_c = ^I_addr[1:0];

`ifdef TIMER_PRESCALE_EN
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_cnt;
  logic               presc_wr_c;

  assign presc_wr_c = wr_c && (off_c == OFF_PRESC);
  assign tick_c     = en && (presc_cnt == presc);

  // Prescaler: counts 0..PRESC while enabled; any PRESC write restarts the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc     <= '0;
      presc_cnt <= '0;
    end else begin
      if (presc_wr_c) presc <= PRESC_W'(merge(DW'(presc), I_wdata, I_mask));
      if (presc_wr_c || tick_c) presc_cnt <= '0;
      else if (en)              presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end
`else
  localparam int unsigned presc_w_unused = PRESC_W;
  assign tick_c = en;
`endif

  // Read mux, sampled from the pre-write state of the request cycle.
  always_comb begin
    rdata_c = '0;
    case (off_c)
      OFF_CTRL:   rdata_c = {30'd0, ie, en};
`ifdef TIMER_PRESCALE_EN
      OFF_PRESC:  rdata_c = DW'(presc);
`endif
      OFF_MT_LO:  rdata_c = mtime[31:0];
      OFF_MT_HI:  rdata_c = mtime[63:32];
      OFF_CMP_LO: rdata_c = mtimecmp[31:0];
      OFF_CMP_HI: rdata_c = mtimecmp[63:32];
      default:    rdata_c = '0;
    endcase
  end

  // mtime next value: a bus write to either half suppresses the tick for all 64 bits.
  always_comb begin
    mtime_nxt_c = mtime;
    if (wr_c && (off_c == OFF_MT_LO))
      mtime_nxt_c = {mtime[63:32], merge(mtime[31:0], I_wdata, I_mask)};
    else if (wr_c && (off_c == OFF_MT_HI))
      mtime_nxt_c = {merge(mtime[63:32], I_wdata, I_mask), mtime[31:0]};
    else if (tick_c)
      mtime_nxt_c = mtime + TW'(1);
  end

  // mtimecmp next value.
  always_comb begin
    mtimecmp_nxt_c = mtimecmp;
    if (wr_c && (off_c == OFF_CMP_LO))
      mtimecmp_nxt_c = {mtimecmp[63:32], merge(mtimecmp[31:0], I_wdata, I_mask)};
    else if (wr_c && (off_c == OFF_CMP_HI))
      mtimecmp_nxt_c = {merge(mtimecmp[63:32], I_wdata, I_mask), mtimecmp[31:0]};
  end

  // State, bus response and interrupt registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      en          <= 1'b0;
      ie          <= 1'b0;
      mtime       <= '0;
      mtimecmp    <= '1;
      O_rdata     <= '0;
      O_ready     <= 1'b0;
      O_timer_int <= 1'b0;
    end else begin
      O_ready <= sel_c;
      O_rdata <= rd_c ? rdata_c : '0;
      if (wr_c && (off_c == OFF_CTRL) && I_mask[0]) begin
        en <= I_wdata[0];
        ie <= I_wdata[1];
      end
      mtime       <= mtime_nxt_c;
      mtimecmp    <= mtimecmp_nxt_c;
      // Compare uses pre-update values, so the interrupt lags by one cycle.
      O_timer_int <= ie && (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: register table plus multi-cycle timer sequences.
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk;
  logic        rst;
  logic        I_req;
  logic        I_we;
  logic [31:0] I_addr;
  logic [31:0] I_wdata;
  logic [3:0]  I_mask;
  logic [31:0] O_rdata;
  logic        O_ready;
  logic        O_timer_int;

  int n_chk  = 0;
  int n_fail = 0;

  clint_timer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .I_req(I_req), .I_we(I_we), .I_addr(I_addr),
    .I_wdata(I_wdata), .I_mask(I_mask), .O_rdata(O_rdata), .O_ready(O_ready),
    .O_timer_int(O_timer_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [31:0] wd;
    logic [3:0]  m;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [2:0] off, input logic [31:0] wd,
                              input logic [3:0] m, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.off = off; v.wd = wd; v.m = m; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request; response is checked and captured #1 after the accepting edge.
  // Consecutive calls produce back-to-back requests.
  task automatic bus(input logic we, input logic [2:0] off, input logic [31:0] wd,
                     input logic [3:0] m, output logic [31:0] rd);
    @(negedge clk);
    I_req = 1'b1; I_we = we; I_addr = BASE | {27'd0, off, 2'b00};
    I_wdata = wd; I_mask = m;
    @(posedge clk); #1;
    check($sformatf("ready_off%0d", off), {63'd0, O_ready}, 64'd1);
    rd = O_rdata;
    I_req = 1'b0; I_we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] wd);
    logic [31:0] d;
    bus(1'b1, off, wd, 4'hF, d);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] off, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, off, 32'd0, 4'h0, d);
    check(name, {32'd0, d}, {32'd0, exp});
  endtask

  // Out-of-window request must not produce a response.
  task automatic no_resp(input logic [31:0] addr, input logic we);
    @(negedge clk);
    I_req = 1'b1; I_we = we; I_addr = addr; I_wdata = 32'h0000_0003; I_mask = 4'hF;
    @(posedge clk); #1;
    check($sformatf("noresp_%h", addr), {63'd0, O_ready}, 64'd0);
    I_req = 1'b0; I_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    logic        any_int;
    logic [31:0] presc_exp;
    logic [31:0] presc_mtime_exp;

`ifdef TIMER_PRESCALE_EN
    presc_exp       = 32'd7;
    presc_mtime_exp = 32'd10;
`else
    presc_exp       = 32'd0;
    presc_mtime_exp = 32'd40;
`endif

    I_req = 1'b0; I_we = 1'b0; I_addr = '0; I_wdata = '0; I_mask = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, O_ready}, 64'd0);
    check("rst_rdata", {32'd0, O_rdata}, 64'd0);
    check("rst_int", {63'd0, O_timer_int}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Register map table, timer stopped so every value is static.
    tbl.push_back(mk(0, 3'd0, 0, 4'h0, 32'h0000_0000));
    tbl.push_back(mk(0, 3'd1, 0, 4'h0, 32'h0000_0000));
    tbl.push_back(mk(0, 3'd2, 0, 4'h0, 32'h0000_0000));
    tbl.push_back(mk(0, 3'd3, 0, 4'h0, 32'h0000_0000));
    tbl.push_back(mk(0, 3'd4, 0, 4'h0, 32'hFFFF_FFFF));
    tbl.push_back(mk(0, 3'd5, 0, 4'h0, 32'hFFFF_FFFF));
    tbl.push_back(mk(0, 3'd6, 0, 4'h0, 32'h0000_0000));
    tbl.push_back(mk(0, 3'd7, 0, 4'h0, 32'h0000_0000));
    tbl.push_back(mk(1, 3'd4, 32'h1234_5678, 4'hF, 32'h0));
    tbl.push_back(mk(0, 3'd4, 0, 4'h0, 32'h1234_5678));
    tbl.push_back(mk(1, 3'd4, 32'hAAAA_BBBB, 4'b0011, 32'h0));
    tbl.push_back(mk(0, 3'd4, 0, 4'h0, 32'h1234_BBBB));
    tbl.push_back(mk(1, 3'd5, 32'hCAFE_F00D, 4'b1100, 32'h0));
    tbl.push_back(mk(0, 3'd5, 0, 4'h0, 32'hCAFE_FFFF));
    tbl.push_back(mk(1, 3'd6, 32'hDEAD_BEEF, 4'hF, 32'h0));
    tbl.push_back(mk(0, 3'd6, 0, 4'h0, 32'h0000_0000));
    tbl.push_back(mk(1, 3'd0, 32'hFFFF_FFFE, 4'hF, 32'h0));
    tbl.push_back(mk(0, 3'd0, 0, 4'h0, 32'h0000_0002));
    tbl.push_back(mk(1, 3'd0, 32'h0000_0003, 4'b1110, 32'h0));
    tbl.push_back(mk(0, 3'd0, 0, 4'h0, 32'h0000_0002));
    tbl.push_back(mk(1, 3'd0, 32'h0000_0000, 4'hF, 32'h0));
    tbl.push_back(mk(1, 3'd3, 32'h0000_0005, 4'hF, 32'h0));
    tbl.push_back(mk(0, 3'd3, 0, 4'h0, 32'h0000_0005));
    tbl.push_back(mk(1, 3'd3, 32'h0000_0000, 4'hF, 32'h0));
    tbl.push_back(mk(1, 3'd1, 32'h0000_0007, 4'hF, 32'h0));
    tbl.push_back(mk(0, 3'd1, 0, 4'h0, presc_exp));
    tbl.push_back(mk(1, 3'd1, 32'h0000_0000, 4'hF, 32'h0));
    tbl.push_back(mk(0, 3'd1, 0, 4'h0, 32'h0000_0000));

    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].off, tbl[i].wd, tbl[i].m, d);
      check($sformatf("vec%0d", i), {32'd0, d}, {32'd0, tbl[i].exp});
    end

    // Response is a single-cycle pulse.
    @(posedge clk); #1;
    check("ready_single", {63'd0, O_ready}, 64'd0);

    // Decode: nothing outside the window responds or writes.
    no_resp(32'h0300_0000, 1'b0);
    no_resp(32'h0200_0020, 1'b1);
    no_resp(32'h01FF_FFFC, 1'b1);
    rd_chk("ctrl_after_nosel", 3'd0, 32'h0);

    // Free-running count: 100 ticks between enable and sample.
    wr(3'd2, 32'h0);
    wr(3'd0, 32'h1);
    repeat (100) @(posedge clk);
    bus(1'b0, 3'd2, 32'd0, 4'h0, d);
    n_chk++;
    if (d < 32'd99 || d > 32'd101) begin
      n_fail++;
      $display("FAIL run100: got %0d expected 99..101", d);
    end
    wr(3'd0, 32'h0);

    // 32-bit carry: two ticks from 0000_0000_FFFF_FFFE.
    wr(3'd2, 32'hFFFF_FFFE);
    wr(3'd3, 32'h0);
    wr(3'd0, 32'h1);
    @(posedge clk);
    wr(3'd0, 32'h0);
    rd_chk("carry_hi", 3'd3, 32'h1);
    rd_chk("carry_lo", 3'd2, 32'h0);

    // 64-bit wrap: one tick from all ones (enable then disable back-to-back).
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd3, 32'hFFFF_FFFF);
    wr(3'd0, 32'h1);
    wr(3'd0, 32'h0);
    rd_chk("wrap_lo", 3'd2, 32'h0);
    rd_chk("wrap_hi", 3'd3, 32'h0);

    // Interrupt at mtime == 50, one cycle late.
    wr(3'd2, 32'h0);
    wr(3'd3, 32'h0);
    wr(3'd5, 32'h0);
    wr(3'd4, 32'd50);
    wr(3'd0, 32'h3);
    for (int k = 1; k <= 55; k++) begin
      @(posedge clk); #1;
      if (k == 50) check("int_before", {63'd0, O_timer_int}, 64'd0);
      if (k == 51) check("int_rise", {63'd0, O_timer_int}, 64'd1);
      if (k == 55) check("int_hold", {63'd0, O_timer_int}, 64'd1);
    end
    wr(3'd5, 32'h1);
    check("int_lag", {63'd0, O_timer_int}, 64'd1);
    @(posedge clk); #1;
    check("int_fall", {63'd0, O_timer_int}, 64'd0);

    // IE = 0: compare true but interrupt never asserts.
    wr(3'd0, 32'h1);
    wr(3'd5, 32'h0);
    any_int = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (O_timer_int) any_int = 1'b1;
    end
    check("int_ie_off", {63'd0, any_int}, 64'd0);
    wr(3'd0, 32'h0);

    // Collision: partial write to MTIME_LO in a tick cycle wins, tick lost.
    wr(3'd2, 32'hABCD_0000);
    wr(3'd3, 32'h0);
    wr(3'd0, 32'h1);
    bus(1'b1, 3'd2, 32'h5555_1234, 4'b0011, d);
    wr(3'd0, 32'h0);
    rd_chk("collide_lo", 3'd2, 32'hABCD_1235);
    rd_chk("collide_hi", 3'd3, 32'h0);

    // Prescaler: PRESC = 3 gives one tick per four cycles when implemented.
    wr(3'd2, 32'h0);
    wr(3'd3, 32'h0);
    wr(3'd1, 32'h3);
    wr(3'd0, 32'h1);
    repeat (40) @(posedge clk);
    rd_chk("presc_mtime", 3'd2, presc_mtime_exp);

    // Reset during a request drops the response and restores reset state.
    @(negedge clk);
    I_req = 1'b1; I_we = 1'b0; I_addr = BASE; I_mask = 4'h0;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ready", {63'd0, O_ready}, 64'd0);
    I_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd_chk("rst2_ctrl", 3'd0, 32'h0);
    rd_chk("rst2_mtime", 3'd2, 32'h0);
    rd_chk("rst2_cmp", 3'd4, 32'hFFFF_FFFF);
    check("rst2_int", {63'd0, O_timer_int}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
